// File: rtl/multiplicador_rpn_if.sv
// Multiplier handshake bundle between the RPN step decoder (master) and the
// shift-add multiplier (slave): StartMult/ProntoMult plus operands and result.
interface multiplicador_rpn_if #(
    parameter int WIDTH = 8
);
    logic               StartMult;
    logic [WIDTH-1:0]   OperandoA;
    logic [WIDTH-1:0]   OperandoB;
    logic               ProntoMult;
    logic [2*WIDTH-1:0] Produto;
    logic               Overflow;
    logic               Ocupado;

    modport master (
        output StartMult, OperandoA, OperandoB,
        input  ProntoMult, Produto, Overflow, Ocupado
    );

    modport slave (
        input  StartMult, OperandoA, OperandoB,
        output ProntoMult, Produto, Overflow, Ocupado
    );
endinterface

// File: rtl/multiplicador_rpn.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Operands are latched on an accepted StartMult (IDLE or DONE only); the
// product, overflow flag and ProntoMult are registered on DONE entry.
// Optional build macro: EARLY_EXIT_EN -- leave CALC as soon as the shifted
// multiplier is exhausted instead of always running WIDTH iterations.
module multiplicador_rpn #(
    parameter int WIDTH = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    multiplicador_rpn_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_mc;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mp;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_produto;
    logic               r_overflow;
    logic               r_pronto;

    logic               w_start;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_start    = bus.StartMult && (r_state != CALC);
    assign w_acc_next = r_acc + (r_mp[0] ? r_mc : '0);

`ifdef EARLY_EXIT_EN
    assign w_last = (r_cnt == LAST_CNT) || ((r_mp >> 1) == '0);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = CALC;
            CALC:    if (w_last)  w_state_next = DONE;
            DONE:    if (w_start) w_state_next = CALC;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, shift-add iteration and result capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mc       <= '0;
            r_acc      <= '0;
            r_mp       <= '0;
            r_cnt      <= '0;
            r_produto  <= '0;
            r_overflow <= 1'b0;
            r_pronto   <= 1'b0;
        end else if (w_start) begin
            r_mc     <= {{WIDTH{1'b0}}, bus.OperandoA};
            r_mp     <= bus.OperandoB;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pronto <= 1'b0;
        end else if (r_state == CALC) begin
            r_acc <= w_acc_next;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_produto  <= w_acc_next;
                r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
                r_pronto   <= 1'b1;
            end
        end
    end

    assign bus.ProntoMult = r_pronto;
    assign bus.Produto    = r_produto;
    assign bus.Overflow   = r_overflow;
    assign bus.Ocupado    = (r_state == CALC);

endmodule

// File: tb/tb_multiplicador_rpn.sv
// Self-checking bench for multiplicador_rpn: directed corner sequences, a
// vector table and randomized operands checked against a plain-arithmetic model.
module tb_multiplicador_rpn;
    localparam int WIDTH = 8;
    localparam int LIMIT = 2 * WIDTH + 4;

    logic Clock;
    logic Reset;

    multiplicador_rpn_if #(.WIDTH(WIDTH)) u_if ();

    multiplicador_rpn #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (u_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_prod;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycles from the accepted start edge until ProntoMult is visible.
    function automatic int exp_latency(input logic [7:0] b);
`ifdef EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
        return (msb + 1 < 1) ? 1 : msb + 1;
`else
        return WIDTH;
`endif
    endfunction

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input string name);
        int          cyc;
        int          occ;
        int          lat;
        logic [15:0] p;
        p   = 16'(a) * 16'(b);
        lat = exp_latency(b);
        @(negedge Clock);
        u_if.StartMult = 1'b1;
        u_if.OperandoA = a;
        u_if.OperandoB = b;
        @(negedge Clock);
        u_if.StartMult = 1'b0;
        u_if.OperandoA = 8'($urandom);
        u_if.OperandoB = 8'($urandom);
        check({name, " pronto_drop"}, 32'(u_if.ProntoMult), 32'd0);
        check({name, " produto_hold"}, 32'(u_if.Produto), 32'(last_prod));
        cyc = 0;
        occ = 0;
        while (!u_if.ProntoMult && cyc < LIMIT) begin
            if (u_if.Ocupado) occ++;
            @(negedge Clock);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " ocupado_cycles"}, 32'(occ), 32'(lat));
        check({name, " produto"}, 32'(u_if.Produto), 32'(p));
        check({name, " overflow"}, 32'(u_if.Overflow), 32'(p > 16'd255));
        check({name, " ocupado_done"}, 32'(u_if.Ocupado), 32'd0);
        last_prod = p;
    endtask

    initial begin
        vec_t vecs[9];
        int   cyc;
        int   bad;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'h008F, ov: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'hFE01, ov: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'h0000, ov: 1'b0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   prod: 16'h0000, ov: 1'b0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   prod: 16'h0001, ov: 1'b0};
        vecs[5] = '{a: 8'd7,   b: 8'd1,   prod: 16'h0007, ov: 1'b0};
        vecs[6] = '{a: 8'd7,   b: 8'h80,  prod: 16'h0380, ov: 1'b1};
        vecs[7] = '{a: 8'd16,  b: 8'd16,  prod: 16'h0100, ov: 1'b1};
        vecs[8] = '{a: 8'd15,  b: 8'd17,  prod: 16'h00FF, ov: 1'b0};

        Reset          = 1'b1;
        u_if.StartMult = 1'b0;
        u_if.OperandoA = '0;
        u_if.OperandoB = '0;
        last_prod      = '0;

        // Reset held for two cycles.
        repeat (2) @(negedge Clock);
        check("reset pronto",   32'(u_if.ProntoMult), 32'd0);
        check("reset produto",  32'(u_if.Produto),    32'd0);
        check("reset overflow", 32'(u_if.Overflow),   32'd0);
        check("reset ocupado",  32'(u_if.Ocupado),    32'd0);
        Reset = 1'b0;

        run_mult(8'd13, 8'd11, "t2 13x11");

        // Maximum operands, then result must stay valid with StartMult low.
        run_mult(8'd255, 8'd255, "t3 255x255");
        bad = 0;
        repeat (20) begin
            @(negedge Clock);
            if (!u_if.ProntoMult || u_if.Produto !== 16'hFE01 || !u_if.Overflow) bad++;
        end
        check("t3 hold 20 cycles bad", 32'(bad), 32'd0);

        // Zero multiplicand; a StartMult pulse during CALC must be ignored.
        @(negedge Clock);
        u_if.StartMult = 1'b1;
        u_if.OperandoA = 8'd0;
        u_if.OperandoB = 8'd200;
        @(negedge Clock);
        u_if.StartMult = 1'b0;
        cyc = 0;
        while (!u_if.ProntoMult && cyc < LIMIT) begin
            if (cyc == 2) begin
                u_if.StartMult = 1'b1;
                u_if.OperandoA = 8'd5;
            end else begin
                u_if.StartMult = 1'b0;
            end
            @(negedge Clock);
            cyc++;
        end
        u_if.StartMult = 1'b0;
        check("t4 latency",  32'(cyc), 32'(exp_latency(8'd200)));
        check("t4 produto",  32'(u_if.Produto),  32'd0);
        check("t4 overflow", 32'(u_if.Overflow), 32'd0);
        last_prod = 16'd0;
        @(negedge Clock);
        check("t4 no restart ocupado", 32'(u_if.Ocupado),    32'd0);
        check("t4 no restart pronto",  32'(u_if.ProntoMult), 32'd1);

        // Reset in the middle of CALC abandons the operation.
        u_if.StartMult = 1'b1;
        u_if.OperandoA = 8'd9;
        u_if.OperandoB = 8'd9;
        @(negedge Clock);
        u_if.StartMult = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("t5 reset pronto",  32'(u_if.ProntoMult), 32'd0);
        check("t5 reset produto", 32'(u_if.Produto),    32'd0);
        check("t5 reset ocupado", 32'(u_if.Ocupado),    32'd0);
        bad = 0;
        repeat (12) begin
            @(negedge Clock);
            if (u_if.ProntoMult || u_if.Ocupado) bad++;
        end
        check("t5 stays idle bad", 32'(bad), 32'd0);
        last_prod = 16'd0;
        run_mult(8'd9, 8'd9, "t5 fresh 9x9");
        check("t5 fresh produto", 32'(u_if.Produto), 32'h0051);

        // Vector table with hand-computed products.
        for (int i = 0; i < 9; i++) begin
            run_mult(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table produto", i), 32'(u_if.Produto), 32'(vecs[i].prod));
            check($sformatf("vec%0d table overflow", i), 32'(u_if.Overflow), 32'(vecs[i].ov));
        end

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = 8'($urandom_range(0, 3));
                1:       rb = 8'(1 << $urandom_range(0, 7));
                default: rb = 8'($urandom_range(0, 255));
            endcase
            run_mult(ra, rb, $sformatf("rand%0d %0dx%0d", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
